// File: rtl/vector_conversion_sequencer_if.sv
// vector_conversion_sequencer_if: shared conversion types plus the operand/result handshake bundle
// The package precedes the interface so that both the bundle and the datapath see the same execution vector type.
package vector_conversion_pkg;
    typedef enum logic [3:0] {
        CVT_NONE,
        SHORTREAL_TO_REAL,
        INT_TO_REAL,
        SHORTREAL_TO_LONGINT,
        REAL_TO_SHORTREAL,
        REAL_TO_INT,
        LONGINT_TO_SHORTREAL,
        INT_TO_SHORTREAL,
        SHORTREAL_TO_INT,
        LONGINT_TO_REAL,
        REAL_TO_LONGINT
    } conversion_mode_t;
    typedef enum logic {SIGN_UNSIGNED, SIGN_SIGNED} sign_mode_t;
    typedef struct packed {
        conversion_mode_t conversion_mode;
        sign_mode_t       sign_mode;
    } execution_vector_t;
    typedef enum logic [1:0] {CLASS_SAME, CLASS_WIDEN, CLASS_NARROW} mode_class_t;
    function automatic mode_class_t mode_class(input conversion_mode_t m);
        case (m)
            SHORTREAL_TO_REAL, INT_TO_REAL, SHORTREAL_TO_LONGINT:       return CLASS_WIDEN;
            REAL_TO_SHORTREAL, REAL_TO_INT, LONGINT_TO_SHORTREAL:       return CLASS_NARROW;
            default:                                                    return CLASS_SAME;
        endcase
    endfunction
endpackage

interface vector_conversion_sequencer_if #(
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = $clog2(LANES + 1)
);
    logic                                  operand_valid;
    logic                                  operand_ready;
    vector_conversion_pkg::execution_vector_t operand_execution_vector;
    logic [LANES*64-1:0]                   operand_vs2;
    logic [COUNT_WIDTH-1:0]                operand_lane_count;
    logic                                  result_valid;
    logic                                  result_ready;
    logic [2*LANES*64-1:0]                 result_data;
    logic [COUNT_WIDTH-1:0]                result_lane_count;
    modport master (
        output operand_valid, operand_execution_vector, operand_vs2, operand_lane_count, result_ready,
        input  operand_ready, result_valid, result_data, result_lane_count
    );
    modport slave (
        input  operand_valid, operand_execution_vector, operand_vs2, operand_lane_count, result_ready,
        output operand_ready, result_valid, result_data, result_lane_count
    );
endinterface

// File: rtl/vector_conversion_sequencer.sv
// vector_conversion_sequencer: converts LANES 64-bit lanes one per cycle through one shared converter
// Define VCU_NARROW_PACK_EN to pack narrowing results densely at 32 bits per lane.
module vector_conversion_unit
    import vector_conversion_pkg::*;
(
    input  execution_vector_t execution_vector,
    input  logic [63:0]       vs2,
    output logic [63:0]       vd,
    output logic [63:0]       vd_high
);
    typedef enum logic [1:0] {FMT_F32, FMT_F64, FMT_I32, FMT_I64} fmt_t;
    typedef struct packed {
        logic        sgn;
        logic        zero;
        logic        inf;
        logic        nan;
        logic [12:0] exp;
        logic [63:0] mant;
    } num_t;

    // Every source is normalised to sign, unbiased exponent and a mantissa with its leading one at bit 63.
    function automatic num_t unpack(input logic [63:0] x, input fmt_t f, input logic sgnd);
        num_t        u;
        logic [63:0] mag;
        logic [6:0]  lz;
        u   = '0;
        mag = '0;
        lz  = '0;
        case (f)
            FMT_F32: begin
                u.sgn  = x[31];
                u.zero = x[30:23] == 8'h00;
                u.inf  = x[30:23] == 8'hff && x[22:0] == 23'h0;
                u.nan  = x[30:23] == 8'hff && x[22:0] != 23'h0;
                u.exp  = 13'(x[30:23]) - 13'd127;
                u.mant = {1'b1, x[22:0], 40'h0};
            end
            FMT_F64: begin
                u.sgn  = x[63];
                u.zero = x[62:52] == 11'h000;
                u.inf  = x[62:52] == 11'h7ff && x[51:0] == 52'h0;
                u.nan  = x[62:52] == 11'h7ff && x[51:0] != 52'h0;
                u.exp  = 13'(x[62:52]) - 13'd1023;
                u.mant = {1'b1, x[51:0], 11'h0};
            end
            default: begin
                u.sgn = sgnd && (f == FMT_I32 ? x[31] : x[63]);
                mag   = f == FMT_I32 ? {32'h0, x[31:0]} : x;
                if (u.sgn)
                    mag = f == FMT_I32 ? {32'h0, -x[31:0]} : -x;
                for (int i = 0; i < 64; i++)
                    if (mag[i])
                        lz = 7'(63 - i);
                u.zero = mag == 64'h0;
                u.exp  = 13'd63 - 13'(lz);
                u.mant = mag << lz;
            end
        endcase
        return u;
    endfunction

    // Rounding is toward zero; float-to-int saturates and maps NaN to 0.
    function automatic logic [63:0] pack(input num_t u, input fmt_t f, input logic sgnd);
        logic signed [12:0] e;
        logic signed [12:0] be;
        logic [64:0]        mag;
        logic [64:0]        lim_neg;
        logic [64:0]        lim_pos;
        logic [63:0]        r;
        e       = u.exp;
        be      = e + (f == FMT_F32 ? 13'sd127 : 13'sd1023);
        mag     = u.inf || e > 13'sd63 ? '1 : u.zero || e < 13'sd0 ? '0 : {1'b0, u.mant >> (13'sd63 - e)};
        lim_neg = f == FMT_I32 ? 65'h8000_0000 : 65'h8000_0000_0000_0000;
        lim_pos = sgnd ? lim_neg - 65'd1 : (lim_neg << 1) - 65'd1;
        case (f)
            FMT_F32: r = u.nan ? 64'h7fc0_0000
                       : u.inf || (!u.zero && be >= 13'sd255) ? {32'h0, u.sgn, 31'h7f80_0000}
                       : u.zero || be <= 13'sd0 ? {32'h0, u.sgn, 31'h0}
                       : {32'h0, u.sgn, be[7:0], u.mant[62:40]};
            FMT_F64: r = u.nan ? 64'h7ff8_0000_0000_0000
                       : u.inf || (!u.zero && be >= 13'sd2047) ? {u.sgn, 63'h7ff0_0000_0000_0000}
                       : u.zero || be <= 13'sd0 ? {u.sgn, 63'h0}
                       : {u.sgn, be[10:0], u.mant[62:11]};
            default: begin
                r = u.nan || (u.sgn && !sgnd) ? 64'h0
                  : u.sgn ? (mag > lim_neg ? -lim_neg[63:0] : -mag[63:0])
                  : (mag > lim_pos ? lim_pos[63:0] : mag[63:0]);
                if (f == FMT_I32)
                    r[63:32] = 32'h0;
            end
        endcase
        return r;
    endfunction

    fmt_t        src;
    fmt_t        dst;
    logic        known;
    logic        sgnd;
    logic [63:0] lo;
    logic [63:0] hi;

    assign sgnd = execution_vector.sign_mode == SIGN_SIGNED;

    always_comb begin
        known = 1'b1;
        src   = FMT_F32;
        dst   = FMT_F32;
        case (execution_vector.conversion_mode)
            SHORTREAL_TO_REAL:    begin src = FMT_F32; dst = FMT_F64; end
            INT_TO_REAL:          begin src = FMT_I32; dst = FMT_F64; end
            SHORTREAL_TO_LONGINT: begin src = FMT_F32; dst = FMT_I64; end
            REAL_TO_SHORTREAL:    begin src = FMT_F64; dst = FMT_F32; end
            REAL_TO_INT:          begin src = FMT_F64; dst = FMT_I32; end
            LONGINT_TO_SHORTREAL: begin src = FMT_I64; dst = FMT_F32; end
            INT_TO_SHORTREAL:     begin src = FMT_I32; dst = FMT_F32; end
            SHORTREAL_TO_INT:     begin src = FMT_F32; dst = FMT_I32; end
            LONGINT_TO_REAL:      begin src = FMT_I64; dst = FMT_F64; end
            REAL_TO_LONGINT:      begin src = FMT_F64; dst = FMT_I64; end
            default:              known = 1'b0;
        endcase
        lo      = pack(unpack(vs2, src, sgnd), dst, sgnd);
        hi      = pack(unpack({32'h0, vs2[63:32]}, src, sgnd), dst, sgnd);
        vd      = !known ? 64'h0
                : mode_class(execution_vector.conversion_mode) == CLASS_SAME && (src == FMT_F32 || src == FMT_I32) ? {hi[31:0], lo[31:0]}
                : lo;
        vd_high = known && mode_class(execution_vector.conversion_mode) == CLASS_WIDEN ? hi : 64'h0;
    end
endmodule

module vector_conversion_sequencer
    import vector_conversion_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = $clog2(LANES + 1)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    vector_conversion_sequencer_if.slave  bus,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] beat;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] clamped;
    execution_vector_t      cap_ev;
    logic [LANES*64-1:0]    cap_vs2;
    logic [63:0]            vd;
    logic [63:0]            vd_high;
    mode_class_t            cls;

    assign clamped = bus.operand_lane_count > COUNT_WIDTH'(LANES) ? COUNT_WIDTH'(LANES) : bus.operand_lane_count;
    assign cls     = mode_class(cap_ev.conversion_mode);

    vector_conversion_unit u_vcu (
        .execution_vector (cap_ev),
        .vs2              (cap_vs2[64*beat +: 64]),
        .vd               (vd),
        .vd_high          (vd_high)
    );

    // beat holds on the final lane so the converter never indexes past the captured operand.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                 <= IDLE;
            beat                  <= '0;
            count                 <= '0;
            cap_ev                <= '0;
            cap_vs2               <= '0;
            bus.operand_ready     <= 1'b1;
            bus.result_valid      <= 1'b0;
            bus.result_data       <= '0;
            bus.result_lane_count <= '0;
            busy                  <= 1'b0;
        end else if (flush) begin
            state             <= IDLE;
            beat              <= '0;
            bus.operand_ready <= 1'b1;
            bus.result_valid  <= 1'b0;
            bus.result_data   <= '0;
            busy              <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.operand_valid) begin
                    cap_ev                <= bus.operand_execution_vector;
                    cap_vs2               <= bus.operand_vs2;
                    count                 <= clamped;
                    bus.result_lane_count <= clamped;
                    bus.result_data       <= '0;
                    beat                  <= '0;
                    bus.operand_ready     <= 1'b0;
                    busy                  <= 1'b1;
                    state                 <= clamped != '0 ? CONVERT : DONE;
                    bus.result_valid      <= clamped == '0;
                end
                CONVERT: begin
                    if (cls == CLASS_WIDEN)
                        bus.result_data[128*beat +: 128] <= {vd_high, vd};
`ifdef VCU_NARROW_PACK_EN
                    else if (cls == CLASS_NARROW)
                        bus.result_data[32*beat +: 32] <= vd[31:0];
`endif
                    else
                        bus.result_data[64*beat +: 64] <= vd;
                    if (beat == count - COUNT_WIDTH'(1)) begin
                        state            <= DONE;
                        bus.result_valid <= 1'b1;
                    end else
                        beat <= beat + COUNT_WIDTH'(1);
                end
                DONE: if (bus.result_ready) begin
                    state             <= IDLE;
                    bus.result_valid  <= 1'b0;
                    bus.operand_ready <= 1'b1;
                    busy              <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_conversion_sequencer.sv
// tb_vector_conversion_sequencer: directed scenarios with hand-computed IEEE-754 results for LANES=4
module tb_vector_conversion_sequencer;
    import vector_conversion_pkg::*;
    localparam int LANES = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    vector_conversion_sequencer_if #(.LANES(LANES)) bus ();

    vector_conversion_sequencer #(.LANES(LANES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one operand from IDLE, scrambles the inputs after acceptance, and reports edges until result_valid.
    task automatic run_op(input conversion_mode_t mode, input sign_mode_t sm, input logic [255:0] vs2, input logic [2:0] cnt, output int lat);
        bus.operand_execution_vector = '{conversion_mode: mode, sign_mode: sm};
        bus.operand_vs2              = vs2;
        bus.operand_lane_count       = cnt;
        bus.operand_valid            = 1'b1;
        tick();
        bus.operand_valid            = 1'b0;
        bus.operand_vs2              = ~vs2;
        bus.operand_execution_vector = '{conversion_mode: CVT_NONE, sign_mode: SIGN_UNSIGNED};
        bus.operand_lane_count       = 3'd1;
        lat = 1;
        while (!bus.result_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.result_valid)
            lat = -1;
    endtask

    task automatic finish_op();
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n                      = 1'b0;
        bus.operand_valid            = 1'b1;
        bus.operand_vs2              = {4{64'h3FF0_0000_0000_0000}};
        bus.operand_lane_count       = 3'd2;
        bus.operand_execution_vector = '{conversion_mode: SHORTREAL_TO_REAL, sign_mode: SIGN_SIGNED};
        tick();
        tick();
        checks++; if (bus.operand_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.operand_ready); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.result_data !== 512'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.result_data); end
        checks++; if (bus.result_lane_count !== 3'd0) begin errors++; $display("FAIL reset_lane_count: got %0d expected 0", bus.result_lane_count); end
        bus.operand_valid = 1'b0;
        reset_n           = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || bus.operand_ready !== 1'b1) begin errors++; $display("FAIL reset_no_accept: got busy=%b ready=%b expected busy=0 ready=1", busy, bus.operand_ready); end
    endtask

    task automatic test_widening();
        int lat;
        run_op(SHORTREAL_TO_REAL, SIGN_SIGNED, {192'h0, 64'h4000_0000_3F80_0000}, 3'd1, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL widen_latency: got %0d expected 2", lat); end
        checks++; if (bus.result_data !== {384'h0, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000}) begin errors++; $display("FAIL widen_data: got %h expected %h", bus.result_data, {384'h0, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000}); end
        checks++; if (bus.result_lane_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL widen_status: got count=%0d busy=%b expected count=1 busy=1", bus.result_lane_count, busy); end
        finish_op();
        checks++; if (bus.operand_ready !== 1'b1 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL widen_release: got ready=%b valid=%b expected ready=1 valid=0", bus.operand_ready, bus.result_valid); end
    endtask

    task automatic test_int_to_shortreal();
        int lat;
        run_op(INT_TO_SHORTREAL, SIGN_SIGNED, {4{64'hFFFF_FFFF_0000_0001}}, 3'd4, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL i2f_latency: got %0d expected 5", lat); end
        checks++; if (bus.result_data !== {256'h0, {4{64'hBF80_0000_3F80_0000}}}) begin errors++; $display("FAIL i2f_signed_data: got %h expected %h", bus.result_data, {256'h0, {4{64'hBF80_0000_3F80_0000}}}); end
        checks++; if (bus.result_lane_count !== 3'd4) begin errors++; $display("FAIL i2f_lane_count: got %0d expected 4", bus.result_lane_count); end
        finish_op();
        run_op(INT_TO_SHORTREAL, SIGN_UNSIGNED, {192'h0, 64'hFFFF_FFFF_0000_0001}, 3'd1, lat);
        checks++; if (bus.result_data !== {448'h0, 64'h4F7F_FFFF_3F80_0000}) begin errors++; $display("FAIL i2f_unsigned_data: got %h expected %h", bus.result_data, {448'h0, 64'h4F7F_FFFF_3F80_0000}); end
        finish_op();
    endtask

    task automatic test_narrowing();
        int lat;
        logic [511:0] exp_data;
`ifdef VCU_NARROW_PACK_EN
        exp_data = {448'h0, 32'h3F80_0000, 32'hC000_0000};
`else
        exp_data = {384'h0, 64'h0000_0000_3F80_0000, 64'h0000_0000_C000_0000};
`endif
        run_op(REAL_TO_SHORTREAL, SIGN_SIGNED, {128'h0, 64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000}, 3'd2, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL narrow_latency: got %0d expected 3", lat); end
        checks++; if (bus.result_data !== exp_data) begin errors++; $display("FAIL narrow_data: got %h expected %h", bus.result_data, exp_data); end
        finish_op();
    endtask

    task automatic test_backpressure_flush();
        int lat;
        logic [511:0] exp_data;
        exp_data = {320'h0, 64'h4000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
        run_op(LONGINT_TO_REAL, SIGN_SIGNED, {64'd5, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1}, 3'd3, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.result_data !== exp_data || bus.result_valid !== 1'b1) begin errors++; $display("FAIL hold_stable cycle %0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.result_valid, bus.result_data, exp_data); end
        end
        flush            = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        flush            = 1'b0;
        bus.result_ready = 1'b0;
        checks++; if (bus.result_valid !== 1'b0 || bus.operand_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_done_state: got valid=%b ready=%b busy=%b expected 0 1 0", bus.result_valid, bus.operand_ready, busy); end
        checks++; if (bus.result_data !== 512'h0) begin errors++; $display("FAIL flush_done_data: got %h expected 0", bus.result_data); end
        bus.operand_execution_vector = '{conversion_mode: LONGINT_TO_REAL, sign_mode: SIGN_SIGNED};
        bus.operand_vs2              = {4{64'd1}};
        bus.operand_lane_count       = 3'd4;
        bus.operand_valid            = 1'b1;
        tick();
        bus.operand_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_convert_busy: got %b expected 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || bus.operand_ready !== 1'b1 || bus.result_data !== 512'h0) begin errors++; $display("FAIL flush_convert_state: got busy=%b ready=%b data=%h expected busy=0 ready=1 data=0", busy, bus.operand_ready, bus.result_data); end
        tick();
        tick();
        tick();
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL flush_convert_no_result: got %b expected 0", bus.result_valid); end
    endtask

    task automatic test_boundary_counts();
        int lat;
        run_op(SHORTREAL_TO_REAL, SIGN_SIGNED, {4{64'h4000_0000_3F80_0000}}, 3'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL count0_latency: got %0d expected 1", lat); end
        checks++; if (bus.result_data !== 512'h0 || bus.result_lane_count !== 3'd0) begin errors++; $display("FAIL count0_result: got count=%0d data=%h expected count=0 data=0", bus.result_lane_count, bus.result_data); end
        finish_op();
        run_op(REAL_TO_LONGINT, SIGN_SIGNED, {64'h0, 64'h4450_0000_0000_0000, 64'hC004_0000_0000_0000, 64'h3FF0_0000_0000_0000}, 3'd7, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL count7_latency: got %0d expected 5", lat); end
        checks++; if (bus.result_lane_count !== 3'd4) begin errors++; $display("FAIL count7_lane_count: got %0d expected 4", bus.result_lane_count); end
        checks++; if (bus.result_data !== {256'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1}) begin errors++; $display("FAIL count7_data: got %h expected %h", bus.result_data, {256'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1}); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [511:0] first;
        first = {384'h0, 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000};
        run_op(INT_TO_REAL, SIGN_SIGNED, {192'h0, 64'hFFFF_FFFE_0000_0003}, 3'd1, lat);
        checks++; if (bus.result_data !== first) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", bus.result_data, first); end
        bus.operand_execution_vector = '{conversion_mode: INT_TO_REAL, sign_mode: SIGN_UNSIGNED};
        bus.operand_vs2              = {192'h0, 64'h0000_0001_0000_0000};
        bus.operand_lane_count       = 3'd1;
        bus.operand_valid            = 1'b1;
        tick();
        checks++; if (bus.result_data !== first || bus.result_valid !== 1'b1) begin errors++; $display("FAIL b2b_done_ignores_operand: got valid=%b data=%h expected valid=1 data=%h", bus.result_valid, bus.result_data, first); end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        checks++; if (bus.result_valid !== 1'b0 || bus.operand_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_no_same_cycle_accept: got valid=%b ready=%b busy=%b expected 0 1 0", bus.result_valid, bus.operand_ready, busy); end
        tick();
        bus.operand_valid = 1'b0;
        bus.operand_vs2   = '1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy); end
        lat = 1;
        while (!bus.result_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 2", lat); end
        checks++; if (bus.result_data !== {384'h0, 64'h3FF0_0000_0000_0000, 64'h0}) begin errors++; $display("FAIL b2b_second_data: got %h expected %h", bus.result_data, {384'h0, 64'h3FF0_0000_0000_0000, 64'h0}); end
        finish_op();
    endtask

    initial begin
        bus.operand_valid            = 1'b0;
        bus.operand_vs2              = '0;
        bus.operand_lane_count       = '0;
        bus.operand_execution_vector = '{conversion_mode: CVT_NONE, sign_mode: SIGN_UNSIGNED};
        bus.result_ready             = 1'b0;
        test_reset();
        test_widening();
        test_int_to_shortreal();
        test_narrowing();
        test_backpressure_flush();
        test_boundary_counts();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_conversion_sequencer.md
Name: vector_conversion_sequencer

Overview:
Multi-lane successor to the single-beat vector conversion datapath. Accepts a LANES×64-bit source operand plus an execution_vector_t under a valid/ready handshake. Converts one 64-bit lane per cycle through a single instantiated vector_conversion_unit and assembles the results, including widening and narrowing placement, into a result buffer. The buffer is presented under a second valid/ready handshake. It sits between the vector issue stage and vector register writeback.

Parameters:
LANES, 4, number of 64-bit source lanes per operation (≥1).
COUNT_WIDTH, $clog2(LANES+1), width of the lane-count fields.

Ports:
clock  input  1  clock
reset_n  input  1  synchronous active-low reset
flush  input  1  synchronous abort of any in-flight operation
operand_valid  input  1  operand offered
operand_ready  output  1  block can accept an operand
operand_execution_vector  input  execution_vector_t  carries conversion_mode and sign_mode
operand_vs2  input  LANES*64  source lanes; lane i = bits [64i+:64]
operand_lane_count  input  COUNT_WIDTH  number of active lanes
result_valid  output  1  result buffer valid
result_ready  input  1  consumer accepts result
result_data  output  2*LANES*64  assembled result
result_lane_count  output  COUNT_WIDTH  lanes actually converted
busy  output  1  high in CONVERT or DONE

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-low on `reset_n`. With reset_n=0 at a clock edge: state=IDLE, operand_ready=1, result_valid=0, busy=0, result_data=0, result_lane_count=0, beat counter=0.
- FSM states: IDLE, CONVERT, DONE.
  - IDLE: operand_ready=1. On operand_valid&operand_ready, capture the execution vector, vs2 and the clamped count into registers, clear result_data, set beat=0. Go to CONVERT if count≠0, else go to DONE (result all zero, result_lane_count=0).
  - CONVERT: operand_ready=0. Each cycle, drive captured lane[beat] and the captured execution vector into the converter, and write vd/vd_high to the buffer. Then beat++. At beat==count-1, go to DONE.
  - DONE: result_valid=1, held stable until result_ready. On result_valid&result_ready, go to IDLE. The next operand cannot be accepted in the same cycle.
- Latency: result_valid rises count+1 cycles after the accepting edge. Throughput is one operation per count+2 cycles.
- Count clamp: operand_lane_count > LANES is treated as LANES.
- Mode classes, taken from the captured conversion_mode:
  - Widening: SHORTREAL_TO_REAL, *_INT_TO_REAL, SHORTREAL_TO_*_LONGINT.
  - Narrowing: REAL_TO_SHORTREAL, REAL_TO_*_INT, *_LONGINT_TO_SHORTREAL.
  - Same-width: all others.
  - Unknown or default modes behave as same-width; the converter yields 0.
- Result placement for lane i:
  - Widening: result_data[128i+:128] = {vd_high, vd}.
  - Same-width: result_data[64i+:64] = vd, and the upper LANES*64 bits are 0.
  - Narrowing: see Optional Feature.
- Lanes ≥ count remain 0.
- Input independence: captured operands are used throughout. Changes on operand_* after acceptance have no effect.
- flush: at any state, the next edge forces IDLE and result_valid=0. The buffer is cleared and the partial result is discarded. flush has priority over every handshake in the same cycle.
- Reset mid-operation: identical to flush, plus all reset values.
- Holding: result_ready while not in DONE is ignored. operand_valid while not in IDLE is ignored and the operand is not consumed.
- result_lane_count equals the clamped count from capture until the next acceptance.

Optional Feature:
Macro VCU_NARROW_PACK_EN.
- Defined: narrowing results are packed densely, with lane i's 32-bit result at result_data[32i+:32]. All bits above LANES*32 are 0.
- Undefined: lane i's narrowing result is at result_data[64i+:64] = vd, with its upper 32 bits 0 as produced by the converter.
- Widening and same-width placement are identical in both builds.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with operand_valid=1 → operand_ready=1, result_valid=0, busy=0, result_data=0; no operand is accepted.
2. Widening, LANES=4: SHORTREAL_TO_REAL with lane0=0x40000000_3F800000 and count=1 → result_data[127:0]={0x4000000000000000, 0x3FF0000000000000}, the rest 0, result_valid 2 cycles after acceptance.
3. Signed int to shortreal: all 4 lanes = 0xFFFFFFFF_00000001 → each result_data[64i+:64]=0xBF800000_3F800000; result_valid 5 cycles after acceptance; result_lane_count=4.
4. Narrowing: REAL_TO_SHORTREAL with lane1=0x3FF0000000000000 and count=2:
   - With VCU_NARROW_PACK_EN: result_data[63:32]=0x3F800000.
   - Without it: result_data[127:64]=0x00000000_3F800000.
5. Backpressure and flush: hold result_ready=0 for 10 cycles in DONE → result_data stable. Then assert flush with result_ready=1 in the same cycle → next cycle IDLE, result_valid=0, no handshake counted.
6. Boundary counts:
   - count=0 → DONE one cycle after acceptance, result all zero.
   - count=7 with LANES=4 → 4 beats converted, result_lane_count=4.
